// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and out_ready; the slave (the adder) returns the result.
interface pipelined_adder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        carry_out;
    logic        overflow;

    modport master (
        output in_valid,
        output input1,
        output input2,
        output carry_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  carry_out,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  input1,
        input  input2,
        input  carry_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output carry_out,
        output overflow
    );
endinterface

// File: rtl/pipelined_adder.sv
// Two-stage 32-bit carry-select adder with valid/ready flow control on both sides.
// Stage 1 adds the low half and both speculative upper halves; stage 2 picks the upper half.
module pipelined_adder (
    input logic              clk,
    input logic              rst,
    pipelined_adder_if.slave bus
);
    logic        s1_valid;
    logic [15:0] s1_lo_sum;
    logic        s1_lo_carry;
    logic [15:0] s1_hi_sum0;
    logic        s1_hi_carry0;
    logic [15:0] s1_hi_sum1;
    logic        s1_hi_carry1;
    logic        s1_sign_a;
    logic        s1_sign_b;

    logic        out_valid_q;
    logic [31:0] out_q;
    logic        carry_q;
    logic        overflow_q;

    logic        s2_load;
    logic        in_ready_c;
    logic        accept;
    logic [16:0] lo_full;
    logic [16:0] hi_full0;
    logic [16:0] hi_full1;
    logic [15:0] sel_sum;
    logic        sel_carry;
    logic        sel_overflow;

    // Stage 1 arithmetic: the upper half is computed for both possible carries.
    always_comb begin
        lo_full  = {1'b0, bus.input1[15:0]} + {1'b0, bus.input2[15:0]} + {16'd0, bus.carry_in};
        hi_full0 = {1'b0, bus.input1[31:16]} + {1'b0, bus.input2[31:16]};
        hi_full1 = hi_full0 + 17'd1;
    end

    always_comb begin
        if (s1_lo_carry) begin
            sel_sum   = s1_hi_sum1;
            sel_carry = s1_hi_carry1;
        end else begin
            sel_sum   = s1_hi_sum0;
            sel_carry = s1_hi_carry0;
        end
        sel_overflow = (s1_sign_a == s1_sign_b) && (sel_sum[15] != s1_sign_a);
    end

    // Stage 2 frees up when empty or when its result is taken this cycle.
    assign s2_load    = !out_valid_q || bus.out_ready;
    assign in_ready_c = !s1_valid || s2_load;
    assign accept     = bus.in_valid && in_ready_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_lo_sum    <= '0;
            s1_lo_carry  <= 1'b0;
            s1_hi_sum0   <= '0;
            s1_hi_carry0 <= 1'b0;
            s1_hi_sum1   <= '0;
            s1_hi_carry1 <= 1'b0;
            s1_sign_a    <= 1'b0;
            s1_sign_b    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            carry_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid     <= 1'b1;
                s1_lo_sum    <= lo_full[15:0];
                s1_lo_carry  <= lo_full[16];
                s1_hi_sum0   <= hi_full0[15:0];
                s1_hi_carry0 <= hi_full0[16];
                s1_hi_sum1   <= hi_full1[15:0];
                s1_hi_carry1 <= hi_full1[16];
                s1_sign_a    <= bus.input1[31];
                s1_sign_b    <= bus.input2[31];
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    out_q      <= {sel_sum, s1_lo_sum};
                    carry_q    <= sel_carry;
                    overflow_q <= sel_overflow;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = overflow_q;
endmodule
